// File: rtl/gmem_m_axi_read_throttle_pkg.sv
// Shared helpers and width derivations for the gmem AXI master read throttle.
package gmem_m_axi_read_throttle_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining / 32'sd2;
        end
        return result;
    endfunction

    // Signed credit width. It has enough headroom for an oversized burst of up to
    // 256 beats to take the credit below zero.
    function automatic int credit_width(input int depth);
        return clog2(depth) + 32'sd10;
    endfunction

    // Outstanding-burst counter width. It must be able to hold MAXREQS itself.
    function automatic int outstanding_width(input int maxreqs);
        return clog2(maxreqs) + 32'sd1;
    endfunction

    // Buffered R entry: {RLAST, RRESP[1:0], RDATA}.
    function automatic int r_entry_width(input int data_width);
        return data_width + 32'sd3;
    endfunction

endpackage

// File: rtl/gmem_m_axi_read_throttle_fifo.sv
// Synchronous FIFO with registered full/empty flags. A word written in one
// cycle is readable in the next cycle. All state advances only when clk_en is high.
module gmem_m_axi_read_throttle_fifo
    import gmem_m_axi_read_throttle_pkg::*;
#(
    parameter int WIDTH = 32'd35,
    parameter int DEPTH = 32'd16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;
    logic [AW-1:0]    wr_ptr_inc_s;
    logic [AW-1:0]    rd_ptr_inc_s;

    assign push_s       = wr_en & ~full_r;
    assign pop_s        = rd_en & ~empty_r;
    assign wr_ptr_inc_s = wr_ptr_r + AW'(1'b1);
    assign rd_ptr_inc_s = rd_ptr_r + AW'(1'b1);

    assign full    = full_r;
    assign empty   = empty_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array. It is not reset; the empty flag keeps stale words from being seen.
    always_ff @(posedge clk) begin
        if (clk_en && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy-flag update. Push and pop together leave the flags unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (clk_en) begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_inc_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            case ({push_s, pop_s})
                2'b10: begin
                    empty_r <= 1'b0;
                    full_r  <= (wr_ptr_inc_s == rd_ptr_r);
                end
                2'b01: begin
                    full_r  <= 1'b0;
                    empty_r <= (rd_ptr_inc_s == wr_ptr_r);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/gmem_m_axi_read_throttle.sv
// Read-side throttle between the kernel and the AXI bus. An AR burst is admitted
// only when buffer space is reserved for all of its beats and the outstanding-burst
// limit has room. R beats are buffered so that the kernel can drain them at its own pace.
module gmem_m_axi_read_throttle
    import gmem_m_axi_read_throttle_pkg::*;
#(
    parameter int ADDR_WIDTH = 32'd32,
    parameter int DATA_WIDTH = 32'd32,
    parameter int DEPTH      = 32'd16,
    parameter int MAXREQS    = 32'd16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH-1:0] in_TOP_ARADDR,
    input  logic [7:0]            in_TOP_ARLEN,
    input  logic                  in_TOP_ARVALID,
    output logic                  out_TOP_ARREADY,
    output logic [ADDR_WIDTH-1:0] out_BUS_ARADDR,
    output logic [7:0]            out_BUS_ARLEN,
    output logic                  out_BUS_ARVALID,
    input  logic                  in_BUS_ARREADY,
    input  logic [DATA_WIDTH-1:0] in_BUS_RDATA,
    input  logic [1:0]            in_BUS_RRESP,
    input  logic                  in_BUS_RLAST,
    input  logic                  in_BUS_RVALID,
    output logic                  out_BUS_RREADY,
    output logic [DATA_WIDTH-1:0] out_TOP_RDATA,
    output logic [1:0]            out_TOP_RRESP,
    output logic                  out_TOP_RLAST,
    output logic                  out_TOP_RVALID,
    input  logic                  in_TOP_RREADY
);

    localparam int CW = credit_width(DEPTH);
    localparam int OW = outstanding_width(MAXREQS);
    localparam int EW = r_entry_width(DATA_WIDTH);

    localparam logic signed [CW-1:0] CREDIT_INIT = CW'(DEPTH);
    localparam logic signed [CW-1:0] CREDIT_ONE  = CW'(1'b1);
    localparam logic signed [CW-1:0] CREDIT_ZERO = CW'(1'b0);
    localparam logic [OW-1:0]        OUT_MAX     = OW'(MAXREQS);

    logic signed [CW-1:0] credit_r;
    logic signed [CW-1:0] credit_nxt_s;
    logic [OW-1:0]        outstanding_r;
    logic [OW-1:0]        outstanding_nxt_s;
    logic [CW-1:0]        arlen_ext_s;
    logic signed [CW-1:0] burst_beats_s;
    logic                 ar_en_s;
    logic                 ar_hs_s;
    logic                 r_pop_s;
    logic                 r_last_in_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [EW-1:0]        fifo_wdata_s;
    logic [EW-1:0]        fifo_rdata_s;

    // Admission decision. It uses registered state only; credit returned in the
    // same cycle is deliberately not counted. An idle buffer accepts any length,
    // which keeps bursts longer than the buffer from deadlocking.
    always_comb begin
        arlen_ext_s   = {{(CW-8){1'b0}}, in_TOP_ARLEN};
        burst_beats_s = $signed(arlen_ext_s + {{(CW-1){1'b0}}, 1'b1});
        ar_en_s       = (outstanding_r < OUT_MAX) &&
                        ((credit_r >= burst_beats_s) || (credit_r == CREDIT_INIT));
    end

    assign out_BUS_ARADDR  = in_TOP_ARADDR;
    assign out_BUS_ARLEN   = in_TOP_ARLEN;
    assign out_BUS_ARVALID = in_TOP_ARVALID & ar_en_s;
    assign out_TOP_ARREADY = in_BUS_ARREADY & ar_en_s;

    assign ar_hs_s     = in_TOP_ARVALID & ar_en_s & in_BUS_ARREADY;
    assign r_pop_s     = ~fifo_empty_s & in_TOP_RREADY;
    assign r_last_in_s = in_BUS_RVALID & ~fifo_full_s & in_BUS_RLAST;

    // Next credit and outstanding values. The AR reservation and the pop return
    // are applied together as a single net change.
    always_comb begin
        credit_nxt_s = credit_r - (ar_hs_s ? burst_beats_s : CREDIT_ZERO)
                                + (r_pop_s ? CREDIT_ONE : CREDIT_ZERO);
        outstanding_nxt_s = outstanding_r;
        case ({ar_hs_s, r_last_in_s})
            2'b10:   outstanding_nxt_s = outstanding_r + OW'(1'b1);
            2'b01:   outstanding_nxt_s = outstanding_r - OW'(1'b1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Credit and outstanding registers. They hold while clk_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_r      <= CREDIT_INIT;
            outstanding_r <= '0;
        end else if (clk_en) begin
            credit_r      <= credit_nxt_s;
            outstanding_r <= outstanding_nxt_s;
        end
    end

    assign fifo_wdata_s = {in_BUS_RLAST, in_BUS_RRESP, in_BUS_RDATA};

    gmem_m_axi_read_throttle_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_rbuf (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .wr_data (fifo_wdata_s),
        .wr_en   (in_BUS_RVALID),
        .full    (fifo_full_s),
        .rd_en   (in_TOP_RREADY),
        .rd_data (fifo_rdata_s),
        .empty   (fifo_empty_s)
    );

    assign out_BUS_RREADY = ~fifo_full_s;
    assign out_TOP_RVALID = ~fifo_empty_s;
    assign out_TOP_RLAST  = fifo_rdata_s[EW-1];
    assign out_TOP_RRESP  = fifo_rdata_s[EW-2:EW-3];
    assign out_TOP_RDATA  = fifo_rdata_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_gmem_m_axi_read_throttle.sv
// Directed bench for gmem_m_axi_read_throttle. The stimulus queues the expected
// AR and R transfers, and independent monitors check them as they appear.
module tb_gmem_m_axi_read_throttle;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int MAXREQS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic [AW-1:0] top_araddr;
    logic [7:0]    top_arlen;
    logic          top_arvalid;
    logic          top_arready;
    logic [AW-1:0] bus_araddr;
    logic [7:0]    bus_arlen;
    logic          bus_arvalid;
    logic          bus_arready;
    logic [DW-1:0] bus_rdata;
    logic [1:0]    bus_rresp;
    logic          bus_rlast;
    logic          bus_rvalid;
    logic          bus_rready;
    logic [DW-1:0] top_rdata;
    logic [1:0]    top_rresp;
    logic          top_rlast;
    logic          top_rvalid;
    logic          top_rready;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    typedef struct packed {
        logic          last;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } r_t;

    ar_t exp_ar_q[$];
    r_t  exp_r_q[$];
    ar_t mon_ar_got;
    ar_t mon_ar_exp;
    r_t  mon_r_got;
    r_t  mon_r_exp;
    int  n_vec = 0;
    int  n_err = 0;

    gmem_m_axi_read_throttle #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAXREQS    (MAXREQS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .in_TOP_ARADDR   (top_araddr),
        .in_TOP_ARLEN    (top_arlen),
        .in_TOP_ARVALID  (top_arvalid),
        .out_TOP_ARREADY (top_arready),
        .out_BUS_ARADDR  (bus_araddr),
        .out_BUS_ARLEN   (bus_arlen),
        .out_BUS_ARVALID (bus_arvalid),
        .in_BUS_ARREADY  (bus_arready),
        .in_BUS_RDATA    (bus_rdata),
        .in_BUS_RRESP    (bus_rresp),
        .in_BUS_RLAST    (bus_rlast),
        .in_BUS_RVALID   (bus_rvalid),
        .out_BUS_RREADY  (bus_rready),
        .out_TOP_RDATA   (top_rdata),
        .out_TOP_RRESP   (top_rresp),
        .out_TOP_RLAST   (top_rlast),
        .out_TOP_RVALID  (top_rvalid),
        .in_TOP_RREADY   (top_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ar(input logic [AW-1:0] a, input logic [7:0] l);
        top_araddr  = a;
        top_arlen   = l;
        top_arvalid = 1'b1;
        exp_ar_q.push_back('{addr: a, len: l});
    endtask

    // Offer one R beat. It waits, within a bounded number of cycles, until the buffer accepts it.
    task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] rs, input logic l);
        bus_rdata  = d;
        bus_rresp  = rs;
        bus_rlast  = l;
        bus_rvalid = 1'b1;
        for (int w = 0; w < 64; w++) begin
            if (bus_rready) begin
                exp_r_q.push_back('{last: l, resp: rs, data: d});
                tick();
                bus_rvalid = 1'b0;
                return;
            end
            tick();
        end
        bus_rvalid = 1'b0;
        check("send_beat_ready", int'(bus_rready), 1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        clk_en      = 1'b1;
        top_araddr  = '0;
        top_arlen   = 8'd0;
        top_arvalid = 1'b0;
        bus_arready = 1'b0;
        bus_rdata   = '0;
        bus_rresp   = 2'd0;
        bus_rlast   = 1'b0;
        bus_rvalid  = 1'b0;
        top_rready  = 1'b0;
        exp_ar_q.delete();
        exp_r_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // AR monitor: every accepted bus request must match the next queued request.
    always @(negedge clk) begin
        if (!reset && clk_en && bus_arvalid && bus_arready) begin
            mon_ar_got = '{addr: bus_araddr, len: bus_arlen};
            n_vec++;
            if (exp_ar_q.size() == 0) begin
                n_err++;
                $display("FAIL ar_unexpected: got addr %h len %0d, expected none", bus_araddr, bus_arlen);
            end else begin
                mon_ar_exp = exp_ar_q.pop_front();
                if (mon_ar_got !== mon_ar_exp) begin
                    n_err++;
                    $display("FAIL ar_pass: got %h/%0d, expected %h/%0d",
                             mon_ar_got.addr, mon_ar_got.len, mon_ar_exp.addr, mon_ar_exp.len);
                end
            end
        end
    end

    // R monitor: every beat consumed by the kernel must match the next queued beat.
    always @(negedge clk) begin
        if (!reset && clk_en && top_rvalid && top_rready) begin
            mon_r_got = '{last: top_rlast, resp: top_rresp, data: top_rdata};
            n_vec++;
            if (exp_r_q.size() == 0) begin
                n_err++;
                $display("FAIL r_unexpected: got %h, expected none", mon_r_got);
            end else begin
                mon_r_exp = exp_r_q.pop_front();
                if (mon_r_got !== mon_r_exp) begin
                    n_err++;
                    $display("FAIL r_beat: got %h, expected %h", mon_r_got, mon_r_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int guard;
        do_reset();
        check("rst_rvalid", int'(top_rvalid), 0);
        check("rst_rready", int'(bus_rready), 1);
        check("rst_credit", int'(dut.credit_r), 16);
        check("rst_out", int'(dut.outstanding_r), 0);

        // Two 8-beat bursts consume all credit. A 1-beat burst then waits for a pop.
        bus_arready = 1'b1;
        issue_ar(32'h0000_1000, 8'd7);
        #1;
        check("t1_arvalid0", int'(bus_arvalid), 1);
        check("t1_arready0", int'(top_arready), 1);
        tick();
        issue_ar(32'h0000_1100, 8'd7);
        tick();
        check("t1_credit0", int'(dut.credit_r), 0);
        check("t1_out2", int'(dut.outstanding_r), 2);
        issue_ar(32'h0000_1200, 8'd0);
        #1;
        check("t1_blk_arvalid", int'(bus_arvalid), 0);
        check("t1_blk_arready", int'(top_arready), 0);
        tick();
        check("t1_blk_arvalid2", int'(bus_arvalid), 0);
        send_beat(32'hA000_0001, 2'd0, 1'b0);
        check("t1_rvalid", int'(top_rvalid), 1);
        check("t1_credit_push", int'(dut.credit_r), 0);
        top_rready = 1'b1;
        #1;
        check("t1_same_cycle_blk", int'(bus_arvalid), 0);
        tick();
        top_rready = 1'b0;
        check("t1_unblk", int'(bus_arvalid), 1);
        tick();
        top_arvalid = 1'b0;
        check("t1_credit_end", int'(dut.credit_r), 0);
        check("t1_out3", int'(dut.outstanding_r), 3);

        // Outstanding limit: four 1-beat bursts fill it. An RLAST return reopens it.
        do_reset();
        bus_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_ar(32'h0000_2000 + 32'(i * 16), 8'd0);
            tick();
        end
        issue_ar(32'h0000_2040, 8'd0);
        #1;
        check("t2_out4", int'(dut.outstanding_r), 4);
        check("t2_blk_arready", int'(top_arready), 0);
        check("t2_blk_arvalid", int'(bus_arvalid), 0);
        tick();
        tick();
        check("t2_still_blk", int'(top_arready), 0);
        send_beat(32'hB000_0000, 2'd1, 1'b1);
        check("t2_reopen", int'(top_arready), 1);
        check("t2_out3", int'(dut.outstanding_r), 3);
        tick();
        top_arvalid = 1'b0;
        check("t2_out_refill", int'(dut.outstanding_r), 4);
        check("t2_credit", int'(dut.credit_r), 11);
        top_rready = 1'b1;
        tick();
        top_rready = 1'b0;
        check("t2_credit_pop", int'(dut.credit_r), 12);
        check("t2_empty", int'(top_rvalid), 0);

        // Oversized 32-beat burst on an idle buffer drives the credit negative.
        do_reset();
        bus_arready = 1'b1;
        issue_ar(32'h0000_3000, 8'd31);
        #1;
        check("t3_idle_admit", int'(bus_arvalid), 1);
        tick();
        top_arvalid = 1'b0;
        check("t3_credit_neg", int'(dut.credit_r), -16);
        check("t3_out1", int'(dut.outstanding_r), 1);
        top_arlen   = 8'd0;
        top_arvalid = 1'b1;
        #1;
        check("t3_probe_blk", int'(bus_arvalid), 0);
        top_arvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h3000_0000 + 32'(i), 2'(i), 1'b0);
        end
        check("t3_full", int'(bus_rready), 0);
        check("t3_credit_full", int'(dut.credit_r), -16);
        top_rready = 1'b1;
        for (int i = 16; i < 32; i++) begin
            send_beat(32'h3000_0000 + 32'(i), 2'(i), (i == 31) ? 1'b1 : 1'b0);
        end
        guard = 0;
        while (top_rvalid && guard < 64) begin
            tick();
            guard++;
        end
        top_rready = 1'b0;
        check("t3_drained", int'(top_rvalid), 0);
        check("t3_credit_back", int'(dut.credit_r), 16);
        check("t3_out0", int'(dut.outstanding_r), 0);
        check("t3_scoreboard", exp_r_q.size(), 0);

        // Same-cycle AR handshake and pop. Then same-cycle AR handshake and RLAST.
        do_reset();
        bus_arready = 1'b1;
        issue_ar(32'h0000_4000, 8'd10);
        tick();
        top_arvalid = 1'b0;
        check("t4_credit5", int'(dut.credit_r), 5);
        send_beat(32'hC000_0000, 2'd0, 1'b0);
        issue_ar(32'h0000_4100, 8'd3);
        top_rready = 1'b1;
        #1;
        check("t4_arvalid", int'(bus_arvalid), 1);
        tick();
        top_arvalid = 1'b0;
        top_rready  = 1'b0;
        check("t4_credit_net", int'(dut.credit_r), 2);
        check("t4_out2", int'(dut.outstanding_r), 2);
        issue_ar(32'h0000_4200, 8'd0);
        check("t4_rready", int'(bus_rready), 1);
        bus_rdata  = 32'hC000_0001;
        bus_rresp  = 2'd2;
        bus_rlast  = 1'b1;
        bus_rvalid = 1'b1;
        exp_r_q.push_back('{last: 1'b1, resp: 2'd2, data: 32'hC000_0001});
        tick();
        bus_rvalid  = 1'b0;
        bus_rlast   = 1'b0;
        top_arvalid = 1'b0;
        check("t4_out_same", int'(dut.outstanding_r), 2);
        check("t4_credit1", int'(dut.credit_r), 1);

        // Reset with six beats buffered and two bursts outstanding.
        for (int i = 2; i < 7; i++) begin
            send_beat(32'hC000_0000 + 32'(i), 2'd0, 1'b0);
        end
        check("t5_pre_rvalid", int'(top_rvalid), 1);
        check("t5_pre_out", int'(dut.outstanding_r), 2);
        reset = 1'b1;
        tick();
        check("t5_rvalid", int'(top_rvalid), 0);
        check("t5_rready", int'(bus_rready), 1);
        check("t5_credit", int'(dut.credit_r), 16);
        check("t5_out", int'(dut.outstanding_r), 0);
        exp_r_q.delete();
        exp_ar_q.delete();
        reset = 1'b0;

        // clk_en stall during traffic: state freezes, and gating stays live.
        bus_arready = 1'b1;
        issue_ar(32'h0000_6000, 8'd3);
        tick();
        top_arvalid = 1'b0;
        send_beat(32'hE000_0000, 2'd1, 1'b0);
        send_beat(32'hE000_0001, 2'd2, 1'b0);
        clk_en = 1'b0;
        issue_ar(32'h0000_6100, 8'd1);
        top_rready = 1'b1;
        #1;
        check("t6_gate_live", int'(bus_arvalid), 1);
        repeat (3) tick();
        check("t6_credit_frozen", int'(dut.credit_r), 12);
        check("t6_out_frozen", int'(dut.outstanding_r), 1);
        check("t6_rvalid_frozen", int'(top_rvalid), 1);
        check("t6_rdata_frozen", int'(top_rdata), int'(32'hE000_0000));
        clk_en = 1'b1;
        tick();
        top_arvalid = 1'b0;
        check("t6_credit_resume", int'(dut.credit_r), 11);
        check("t6_out_resume", int'(dut.outstanding_r), 2);
        tick();
        top_rready = 1'b0;
        check("t6_credit_end", int'(dut.credit_r), 12);
        check("t6_empty", int'(top_rvalid), 0);
        check("t6_r_scoreboard", exp_r_q.size(), 0);
        check("t6_ar_scoreboard", exp_ar_q.size(), 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gmem_m_axi_read_throttle.md
Name: gmem_m_axi_read_throttle

Overview:
- Read-direction counterpart of the gmem AXI master write throttle: sits between the kernel-side read request/response ports (TOP) and the AXI bus (BUS) on the AR and R channels.
- Admits an AR burst only when the local R-data buffer has space reserved for every beat of that burst, and fewer than MAXREQS bursts are outstanding.
- Returning R beats never stall the bus in normal operation; the kernel drains them from the buffer at its own pace.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width.
- DEPTH, 16, R buffer depth in beats; power of 2, at least 2.
- MAXREQS, 16, maximum outstanding AR bursts; at least 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous active-high reset.
- clk_en  in  1  state-update enable; when low, all registers hold.
- in_TOP_ARADDR  in  ADDR_WIDTH  kernel read address.
- in_TOP_ARLEN  in  8  kernel burst length minus 1.
- in_TOP_ARVALID  in  1  kernel request valid.
- out_TOP_ARREADY  out  1  request accepted.
- out_BUS_ARADDR  out  ADDR_WIDTH  bus address, equal to in_TOP_ARADDR.
- out_BUS_ARLEN  out  8  bus length, equal to in_TOP_ARLEN.
- out_BUS_ARVALID  out  1  gated request valid.
- in_BUS_ARREADY  in  1  bus accepts AR.
- in_BUS_RDATA  in  DATA_WIDTH  bus read data.
- in_BUS_RRESP  in  2  bus response.
- in_BUS_RLAST  in  1  last beat of burst.
- in_BUS_RVALID  in  1  bus beat valid.
- out_BUS_RREADY  out  1  buffer not full.
- out_TOP_RDATA  out  DATA_WIDTH  buffered data.
- out_TOP_RRESP  out  2  buffered response.
- out_TOP_RLAST  out  1  buffered last flag.
- out_TOP_RVALID  out  1  buffer not empty.
- in_TOP_RREADY  in  1  kernel consumes beat.

Behaviour:
- State registers:
  - credit: signed, CW = log2(DEPTH)+10 bits, reset value DEPTH.
  - outstanding: log2(MAXREQS)+1 bits, reset value 0.
- Request enable, combinational from registered state and in_TOP_ARLEN:
  - ar_en = (outstanding < MAXREQS) & ((credit >= ARLEN+1) | (credit == DEPTH)).
  - The credit == DEPTH term admits bursts longer than DEPTH when the buffer is idle, which prevents deadlock.
  - ar_en does not account for same-cycle credit returns; this conservative rule is intentional.
- AR channel gating:
  - out_BUS_ARVALID = in_TOP_ARVALID & ar_en.
  - out_TOP_ARREADY = in_BUS_ARREADY & ar_en.
  - Address and length are pure pass-through; zero added latency on AR.
- Events:
  - ar_hs = out_BUS_ARVALID & in_BUS_ARREADY.
  - r_pop = out_TOP_RVALID & in_TOP_RREADY.
  - r_last_in = in_BUS_RVALID & out_BUS_RREADY & in_BUS_RLAST.
- Update rule when clk_en is high: credit <= credit - (ar_hs ? ARLEN+1 : 0) + (r_pop ? 1 : 0).
  - Simultaneous AR handshake and pop apply their net effect in one cycle.
  - credit may go negative, with a minimum of DEPTH-256, only after an oversized burst.
- outstanding update:
  - +1 on ar_hs, -1 on r_last_in; both in the same cycle leaves it unchanged.
  - Never exceeds MAXREQS and never underflows under a legal bus.
- R buffer:
  - FIFO of DEPTH entries, entry = {RLAST, RRESP, RDATA}.
  - Push on in_BUS_RVALID & out_BUS_RREADY; pop on r_pop.
  - out_BUS_RREADY = not full.
  - First-word latency: a beat pushed in cycle N is visible on out_TOP_* in cycle N+1.
  - Full FIFO with simultaneous push and pop: RREADY is still low that cycle (full is registered).
  - Empty FIFO with simultaneous push and pop: the pop is ignored because RVALID is low.
- Reset values:
  - out_TOP_RVALID = 0.
  - out_BUS_RREADY = 1.
  - ar_en = 1, so out_BUS_ARVALID follows in_TOP_ARVALID.
  - FIFO is emptied.
- Reset mid-operation drops buffered beats and outstanding bookkeeping. The bus side must also be reset in that case.
- With clk_en low:
  - Combinational gating stays live from held state.
  - No counter or FIFO updates occur; handshakes in that cycle are not counted. The integration guarantees the bus side is stalled as well.

Decomposition:
- Shared package:
  - log2 function.
  - Credit-width and outstanding-width constants derived from DEPTH and MAXREQS.
  - R entry width constant DATA_WIDTH+3.
- One sub-module: gmem_m_axi_read_throttle_fifo, a synchronous FIFO with registered full/empty flags, clk_en-gated, with first-word latency 1.

Test Plan:
- DEPTH=16, MAXREQS=4, TOP ARLEN=7 twice back-to-back, RREADY held low -> both ARs accepted, credit=0; third ARLEN=0 blocked (ARVALID out = 0) until one r_pop, then accepted next cycle.
- MAXREQS=2, four ARLEN=0 requests, bus withholds R -> two accepted, out_TOP_ARREADY=0 for the rest; one RLAST beat returns -> third accepted the following cycle.
- Credit DEPTH=16 and idle, ARLEN=31 -> accepted, credit=-16; bus pushes 32 beats; RREADY drops when 16 are buffered; kernel drains all 32 -> credit returns to 16, data order and RLAST on beat 32 preserved.
- Same cycle AR handshake (ARLEN=3) and r_pop with credit=5 -> credit=2 next cycle; simultaneous ar_hs and r_last_in -> outstanding unchanged.
- Assert reset with 6 beats buffered and 2 outstanding -> next cycle out_TOP_RVALID=0, out_BUS_RREADY=1, credit=16, outstanding=0.
- clk_en=0 for 3 cycles during traffic -> counters and FIFO contents frozen; resuming clk_en gives the same results as without the stall.
